// File: rtl/seq_divider_if.sv
// Handshake/payload bundle for seq_divider.
//   master : operand producer and result consumer (drives in_valid, dividend, divisor, out_ready)
//   slave  : the divider (drives in_ready, out_valid, quotient, remainder, div_by_zero)
interface seq_divider_if #(
    parameter int unsigned DIV_WIDTH = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per cycle, MSB first.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : seq_divider_if.slave
//              in_valid/in_ready + dividend/divisor   operand handshake
//              out_valid/out_ready + quotient/remainder/div_by_zero   result handshake
// One division in flight; results are held under back-pressure until out_ready.
module seq_divider #(
    parameter int unsigned DIV_WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int unsigned W     = DIV_WIDTH;
    localparam int unsigned CNT_W = (DIV_WIDTH > 2) ? $clog2(DIV_WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [W-1:0]     rem_q,   rem_d;   // partial remainder (always < divisor between steps)
    logic [W-1:0]     quo_q,   quo_d;   // dividend shifts out, quotient shifts in
    logic [W-1:0]     dsr_q,   dsr_d;
    logic             dbz_q,   dbz_d;
    logic [W:0]       r_shift;          // one extra bit so compare/subtract cannot overflow

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and restoring-division step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        dbz_d   = dbz_q;
        r_shift = {rem_q, quo_q[W-1]};

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    dsr_d = bus.divisor;
                    if (bus.divisor == '0) begin
                        dbz_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        state_d = S_DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        quo_d   = bus.dividend;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(DIV_WIDTH - 1);
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                // Result of a successful subtract is < divisor, so it fits in W bits
                if (r_shift >= {1'b0, dsr_q}) begin
                    rem_d = W'(r_shift - {1'b0, dsr_q});
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = W'(r_shift);
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
    localparam int unsigned W      = 64;
    localparam int unsigned N_RAND = 120;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    seq_divider_if #(.DIV_WIDTH(W)) bus ();

    seq_divider #(.DIV_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction; all tasks start and end #1 after a rising edge.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] eq, input logic [63:0] er, input logic edbz,
                          input int hold, input int pre_idle);
        int n;
        logic unstable;
        repeat (pre_idle) begin @(posedge clk); #1; end
        n = 0;
        while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
        check({tag, "_in_ready_wait"}, 64'(bus.in_ready), 64'd1);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        // Keep in_valid high with junk operands: must be ignored while busy/done
        bus.dividend = {$urandom, $urandom};
        bus.divisor  = 64'd3;
        n = 0;
        while (!bus.out_valid && n < int'(W) + 5) begin @(posedge clk); #1; n++; end
        check({tag, "_latency"}, 64'(n), (b == 64'd0) ? 64'd0 : 64'(W));
        unstable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.out_ready = 1'b0;
            @(posedge clk); #1;
            if (!bus.out_valid || bus.in_ready || bus.quotient !== eq ||
                bus.remainder !== er || bus.div_by_zero !== edbz)
                unstable = 1'b1;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 64'(unstable), 64'd0);
        bus.in_valid = 1'b0;
        check({tag, "_q"},   bus.quotient,         eq);
        check({tag, "_r"},   bus.remainder,        er);
        check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_handoff"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    endtask

    initial begin
        logic [63:0] a, b, eq, er;
        logic        stray;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_in_ready",  64'(bus.in_ready),    64'd1);
        check("rst_out_valid", 64'(bus.out_valid),   64'd0);
        check("rst_q",         bus.quotient,         64'd0);
        check("rst_r",         bus.remainder,        64'd0);
        check("rst_dbz",       64'(bus.div_by_zero), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors
        run_op("basic",   64'd100,   64'd7, 64'd14, 64'd2, 1'b0, 0, 0);
        run_op("dbz",     64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd12345, 1'b1, 0, 1);
        run_op("max_1",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 0, 0);
        run_op("small",   64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 0, 2);
        run_op("max_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 0, 0);
        run_op("pow2",    64'h8000_0000_0000_0000, 64'd2, 64'h4000_0000_0000_0000, 64'd0, 1'b0, 0, 0);
        run_op("bp",      64'd1000, 64'd7, 64'd142, 64'd6, 1'b0, 20, 0);
        run_op("dbz_clr", 64'd77, 64'd10, 64'd7, 64'd7, 1'b0, 0, 0);

        // Reset in the middle of 1000/3, after step 30
        bus.dividend = 64'd1000;
        bus.divisor  = 64'd3;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  64'(bus.in_ready),    64'd1);
        check("mid_rst_out_valid", 64'(bus.out_valid),   64'd0);
        check("mid_rst_q",         bus.quotient,         64'd0);
        check("mid_rst_r",         bus.remainder,        64'd0);
        check("mid_rst_dbz",       64'(bus.div_by_zero), 64'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < int'(W) + 5; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) stray = 1'b1;
        end
        check("mid_rst_no_result", 64'(stray), 64'd0);
        run_op("after_rst", 64'd1000, 64'd3, 64'd333, 64'd1, 1'b0, 0, 0);

        // Random operand pairs against a '/' and '%' model
        for (int k = 0; k < int'(N_RAND); k++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = 64'd0;
                1:       b = 64'($urandom_range(1, 20));
                2:       b = {32'd0, $urandom} | 64'd1;
                default: b = {$urandom, $urandom};
            endcase
            if (b == 64'd0) begin
                eq = 64'hFFFF_FFFF_FFFF_FFFF;
                er = a;
            end else begin
                eq = a / b;
                er = a % b;
            end
            run_op($sformatf("rnd%0d", k), a, b, eq, er, (b == 64'd0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
